// File: rtl/uart_rx_cfg.sv
// uart_rx_cfg: parametrised UART receiver with parity/stop checks, false-start rejection and valid/ready output
module uart_rx_cfg #(
  parameter int CLKS_PER_BIT = 5208,
  parameter int DATA_BITS    = 8,
  parameter int PARITY       = 0,
  parameter int STOP_BITS    = 1
) (
  input  logic                 clk,
  input  logic                 arst,
  input  logic                 rx,
  input  logic                 rx_ready,
  output logic [DATA_BITS-1:0] rx_data,
  output logic                 rx_valid,
  output logic                 parity_err,
  output logic                 frame_err,
  output logic                 overrun,
  output logic                 busy
);
  localparam int CW = $clog2(CLKS_PER_BIT);
  localparam int BW = $clog2(DATA_BITS + 1);
  typedef enum logic [2:0] {IDLE, START, DATA, PAR, STOP, LOAD, HUNT} state_t;
  state_t state, state_n;
  logic [1:0] sync;
  logic rx_s, rx_q, tick, last, perr, ferr;
  logic [CW-1:0] cnt;
  logic [BW-1:0] bcnt;
  logic [DATA_BITS-1:0] shreg;
  assign rx_s = sync[1];
  assign busy = state != IDLE;
  // START waits half a bit to land mid start bit; later states sample a full bit apart
  always_comb begin
    tick = cnt == ((state == START) ? CW'(CLKS_PER_BIT/2 - 1) : CW'(CLKS_PER_BIT - 1));
    last = bcnt == ((state == DATA) ? BW'(DATA_BITS - 1) : BW'(STOP_BITS - 1));
    state_n = state;
    case (state)
      IDLE:    state_n = (rx_q && !rx_s) ? START : IDLE;
      START:   state_n = !tick ? START : rx_s ? IDLE : DATA;
      DATA:    state_n = !(tick && last) ? DATA : (PARITY != 0) ? PAR : STOP;
      PAR:     state_n = tick ? STOP : PAR;
      STOP:    state_n = (tick && last) ? LOAD : STOP;
      LOAD:    state_n = ferr ? HUNT : IDLE;
      HUNT:    state_n = rx_s ? IDLE : HUNT;
      default: state_n = IDLE;
    endcase
  end
  always_ff @(posedge clk or posedge arst) begin
    if (arst) begin
      state      <= IDLE;
      sync       <= 2'b11;
      rx_q       <= 1'b1;
      cnt        <= '0;
      bcnt       <= '0;
      shreg      <= '0;
      perr       <= 1'b0;
      ferr       <= 1'b0;
      rx_data    <= '0;
      rx_valid   <= 1'b0;
      parity_err <= 1'b0;
      frame_err  <= 1'b0;
      overrun    <= 1'b0;
    end else begin
      state <= state_n;
      sync  <= {sync[0], rx};
      rx_q  <= rx_s;
      cnt   <= (tick || state_n != state) ? '0 : cnt + 1'b1;
      bcnt  <= (state_n != state) ? '0 : bcnt + BW'(tick);
      if (state == DATA && tick) shreg <= {rx_s, shreg[DATA_BITS-1:1]};
      if (state == IDLE) begin
        perr <= 1'b0;
        ferr <= 1'b0;
      end
      if (state == PAR && tick) perr <= ^{shreg, rx_s} ^ (PARITY == 1);
      if (state == STOP && tick && !rx_s) ferr <= 1'b1;
      if (state == LOAD) begin
        rx_data    <= shreg;
        parity_err <= perr;
        frame_err  <= ferr;
      end
      rx_valid <= (state == LOAD) || (rx_valid && !rx_ready);
      overrun  <= (state == LOAD && rx_valid && !rx_ready) || (overrun && !(rx_valid && rx_ready));
    end
  end
endmodule

// File: tb/tb_uart_rx_cfg.sv
// tb_uart_rx_cfg: three receiver configurations (8N1, 8E2, 9O1) driven with directed and random frames
module tb_uart_rx_cfg;
  localparam int CPB = 16;
  typedef struct {int s; logic [8:0] d; logic p; logic f;} word_t;
  logic clk = 1'b0;
  logic arst = 1'b1;
  logic [2:0] rx = 3'b111;
  logic [2:0] rdy = 3'b111;
  logic [2:0] vld, perr, ferr, ovr, bsy;
  logic [8:0] dout [3];
  int vcnt [3] = '{0, 0, 0};
  word_t q[$];
  int n_tests = 0;
  int n_fail = 0;
  always #5 clk = ~clk;

  function automatic int db(int s); return s == 2 ? 9 : 8; endfunction
  function automatic int pa(int s); return s == 0 ? 0 : s == 1 ? 2 : 1; endfunction
  function automatic int sb(int s); return s == 1 ? 2 : 1; endfunction

  for (genvar g = 0; g < 3; g++) begin : g_u
    localparam int DB = (g == 2) ? 9 : 8;
    logic [DB-1:0] d;
    uart_rx_cfg #(.CLKS_PER_BIT(CPB), .DATA_BITS(DB), .PARITY(g == 0 ? 0 : g == 1 ? 2 : 1),
                  .STOP_BITS(g == 1 ? 2 : 1)) u (
      .clk(clk), .arst(arst), .rx(rx[g]), .rx_ready(rdy[g]), .rx_data(d), .rx_valid(vld[g]),
      .parity_err(perr[g]), .frame_err(ferr[g]), .overrun(ovr[g]), .busy(bsy[g]));
    assign dout[g] = 9'(d);
    always @(negedge clk) begin
      if (vld[g]) vcnt[g]++;
      if (vld[g] && rdy[g]) q.push_back(word_t'{g, dout[g], perr[g], ferr[g]});
    end
  end

  task automatic idle(input int n);
    repeat (n) @(negedge clk);
  endtask

  // start bit, data LSB first, optional parity, stop bits; gl inverts one cycle early in each bit
  task automatic send(input int s, input logic [8:0] d, input logic pb, input logic [1:0] st, input bit gl);
    logic bits[$];
    bits.push_back(1'b0);
    for (int i = 0; i < db(s); i++) bits.push_back(d[i]);
    if (pa(s) != 0) bits.push_back(pb);
    for (int i = 0; i < sb(s); i++) bits.push_back(st[i]);
    foreach (bits[k])
      for (int c = 0; c < CPB; c++) begin
        @(negedge clk);
        rx[s] = (gl && k > 0 && c == 2) ? ~bits[k] : bits[k];
      end
  endtask

  task automatic get_word(output word_t w, output bit ok);
    ok = 1'b0;
    w = word_t'{-1, 9'h0, 1'b0, 1'b0};
    for (int i = 0; i < 40 * CPB && !ok; i++)
      if (q.size() > 0) begin
        w = q.pop_front();
        ok = 1'b1;
      end else @(negedge clk);
  endtask

  task automatic test_reset;
    arst = 1'b1;
    idle(3);
    for (int g = 0; g < 3; g++) begin
      n_tests++;
      if ({vld[g], perr[g], ferr[g], ovr[g], bsy[g]} !== 5'b0 || dout[g] !== 9'h0) begin
        n_fail++;
        $display("FAIL reset[%0d] flags=%b data=%h expected all zero", g, {vld[g], perr[g], ferr[g], ovr[g], bsy[g]}, dout[g]);
      end
    end
    arst = 1'b0;
    idle(4);
  endtask

  task automatic test_8n1;
    word_t w;
    bit ok;
    int v0;
    rdy[0] = 1'b1;
    v0 = vcnt[0];
    send(0, 9'h0A5, 1'b0, 2'b11, 1'b0);
    rx[0] = 1'b1;
    get_word(w, ok);
    idle(2);
    n_tests++; if (!ok) begin n_fail++; $display("FAIL t1_timeout no word"); end
    n_tests++; if (w.d !== 9'h0A5) begin n_fail++; $display("FAIL t1_data got %h exp a5", w.d); end
    n_tests++; if ({w.p, w.f} !== 2'b00) begin n_fail++; $display("FAIL t1_err got p=%b f=%b exp 0 0", w.p, w.f); end
    n_tests++; if (vcnt[0] - v0 !== 1) begin n_fail++; $display("FAIL t1_pulse valid cycles %0d exp 1", vcnt[0] - v0); end
    n_tests++; if (bsy[0] !== 1'b0) begin n_fail++; $display("FAIL t1_busy got %b exp 0", bsy[0]); end
  endtask

  task automatic test_parity;
    word_t w;
    bit ok;
    rdy[1] = 1'b1;
    for (int pb = 1; pb >= 0; pb--) begin
      send(1, 9'h007, 1'(pb), 2'b11, 1'b0);
      rx[1] = 1'b1;
      get_word(w, ok);
      idle(CPB);
      n_tests++;
      if (!ok || w.d !== 9'h007 || w.p !== 1'(pb == 0) || w.f !== 1'b0) begin
        n_fail++;
        $display("FAIL t2_parity pb=%0d got ok=%b d=%h p=%b f=%b exp d=07 p=%b f=0", pb, ok, w.d, w.p, w.f, pb == 0);
      end
    end
  endtask

  task automatic test_hunt;
    word_t w;
    bit ok;
    rdy[1] = 1'b1;
    send(1, 9'h03C, 1'b0, 2'b01, 1'b0);
    repeat (40 * CPB) begin @(negedge clk); rx[1] = 1'b0; end
    get_word(w, ok);
    n_tests++;
    if (!ok || w.d !== 9'h03C || w.p !== 1'b0 || w.f !== 1'b1) begin
      n_fail++;
      $display("FAIL t3_ferr got ok=%b d=%h p=%b f=%b exp d=3c p=0 f=1", ok, w.d, w.p, w.f);
    end
    n_tests++; if (q.size() !== 0 || bsy[1] !== 1'b1) begin n_fail++; $display("FAIL t3_hunt words=%0d busy=%b exp 0 1", q.size(), bsy[1]); end
    rx[1] = 1'b1;
    idle(2 * CPB);
    n_tests++; if (bsy[1] !== 1'b0) begin n_fail++; $display("FAIL t3_idle busy=%b exp 0", bsy[1]); end
    send(1, 9'h055, 1'b0, 2'b11, 1'b0);
    rx[1] = 1'b1;
    get_word(w, ok);
    idle(CPB);
    n_tests++;
    if (!ok || w.d !== 9'h055 || w.p !== 1'b0 || w.f !== 1'b0) begin
      n_fail++;
      $display("FAIL t3_recover got ok=%b d=%h p=%b f=%b exp d=55 p=0 f=0", ok, w.d, w.p, w.f);
    end
  endtask

  task automatic test_false_start;
    int v0;
    v0 = vcnt[0];
    @(negedge clk);
    rx[0] = 1'b0;
    idle(4);
    rx[0] = 1'b1;
    n_tests++; if (bsy[0] !== 1'b1) begin n_fail++; $display("FAIL t4_start busy=%b exp 1", bsy[0]); end
    idle(CPB / 2 + 3 - 4);
    n_tests++; if (bsy[0] !== 1'b0) begin n_fail++; $display("FAIL t4_abort busy=%b exp 0", bsy[0]); end
    idle(2 * CPB);
    n_tests++; if (vcnt[0] !== v0 || q.size() !== 0) begin n_fail++; $display("FAIL t4_nooutput valid cycles %0d words %0d exp 0 0", vcnt[0] - v0, q.size()); end
  endtask

  task automatic test_overrun;
    rdy[0] = 1'b0;
    send(0, 9'h011, 1'b0, 2'b11, 1'b0);
    rx[0] = 1'b1;
    idle(CPB);
    n_tests++;
    if (vld[0] !== 1'b1 || dout[0] !== 9'h011 || ovr[0] !== 1'b0) begin
      n_fail++;
      $display("FAIL t5_first v=%b d=%h ovr=%b exp 1 11 0", vld[0], dout[0], ovr[0]);
    end
    send(0, 9'h022, 1'b0, 2'b11, 1'b0);
    rx[0] = 1'b1;
    idle(CPB);
    n_tests++;
    if (vld[0] !== 1'b1 || dout[0] !== 9'h022 || ovr[0] !== 1'b1) begin
      n_fail++;
      $display("FAIL t5_overrun v=%b d=%h ovr=%b exp 1 22 1", vld[0], dout[0], ovr[0]);
    end
    @(negedge clk);
    rdy[0] = 1'b1;
    @(negedge clk);
    rdy[0] = 1'b0;
    n_tests++; if (vld[0] !== 1'b0 || ovr[0] !== 1'b0) begin n_fail++; $display("FAIL t5_accept v=%b ovr=%b exp 0 0", vld[0], ovr[0]); end
    idle(2);
    q.delete();
    rdy[0] = 1'b1;
  endtask

  task automatic test_reset_mid;
    word_t w;
    bit ok;
    rdy[0] = 1'b0;
    send(0, 9'h05A, 1'b0, 2'b11, 1'b0);
    rx[0] = 1'b1;
    idle(CPB);
    for (int c = 0; c < 4 * CPB + CPB / 2; c++) begin
      @(negedge clk);
      rx[0] = (c < CPB) ? 1'b0 : 1'b1;
    end
    n_tests++; if ({vld[0], bsy[0]} !== 2'b11) begin n_fail++; $display("FAIL t6_pre v=%b busy=%b exp 1 1", vld[0], bsy[0]); end
    @(negedge clk);
    arst = 1'b1;
    @(negedge clk);
    n_tests++;
    if ({vld[0], perr[0], ferr[0], ovr[0], bsy[0]} !== 5'b0 || dout[0] !== 9'h0) begin
      n_fail++;
      $display("FAIL t6_reset flags=%b data=%h exp all zero", {vld[0], perr[0], ferr[0], ovr[0], bsy[0]}, dout[0]);
    end
    arst = 1'b0;
    rdy[0] = 1'b1;
    idle(2 * CPB);
    n_tests++; if (q.size() !== 0 || vld[0] !== 1'b0) begin n_fail++; $display("FAIL t6_partial words=%0d v=%b exp 0 0", q.size(), vld[0]); end
    send(0, 9'h081, 1'b0, 2'b11, 1'b0);
    rx[0] = 1'b1;
    get_word(w, ok);
    idle(CPB);
    n_tests++;
    if (!ok || w.d !== 9'h081 || w.p !== 1'b0 || w.f !== 1'b0) begin
      n_fail++;
      $display("FAIL t6_after got ok=%b d=%h p=%b f=%b exp d=81 p=0 f=0", ok, w.d, w.p, w.f);
    end
  endtask

  task automatic test_random;
    word_t w;
    bit ok;
    for (int i = 0; i < 30; i++) begin
      int s, ones;
      logic [8:0] d;
      logic pb, ep, ef, gl;
      logic [1:0] st;
      s = $urandom_range(0, 2);
      d = 9'($urandom) & 9'((1 << db(s)) - 1);
      pb = 1'($urandom_range(0, 1));
      st = ($urandom_range(0, 3) == 0) ? 2'($urandom_range(0, 3)) : 2'b11;
      gl = 1'($urandom_range(0, 1));
      ones = $countones(d) + int'(pb);
      ep = (pa(s) == 0) ? 1'b0 : (pa(s) == 1) ? (ones % 2 == 0) : (ones % 2 == 1);
      ef = !st[0] || (sb(s) == 2 && !st[1]);
      rdy[s] = 1'b1;
      send(s, d, pb, st, gl);
      rx[s] = 1'b1;
      get_word(w, ok);
      idle(CPB);
      n_tests++;
      if (!ok || w.s !== s || w.d !== d || w.p !== ep || w.f !== ef) begin
        n_fail++;
        $display("FAIL rand[%0d] inst=%0d got ok=%b inst=%0d d=%h p=%b f=%b exp d=%h p=%b f=%b", i, s, ok, w.s, w.d, w.p, w.f, d, ep, ef);
      end
    end
  endtask

  initial begin
    test_reset;
    test_8n1;
    test_parity;
    test_hunt;
    test_false_start;
    test_overrun;
    test_reset_mid;
    test_random;
    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

  initial begin
    #5ms;
    $display("FAIL watchdog simulation did not finish");
    $fatal(1);
  end
endmodule
